// File: rtl/hyperbus_cfg_boot_seq.sv
// Boot-time sequencer: writes and reads back every Hyperbus timing word and chip
// range after reset, then hands the configuration register port to the SoC host.
module hyperbus_cfg_boot_seq #(
  parameter int unsigned NumChips              = 2,
  parameter int unsigned StartDelay            = 16,
  parameter int unsigned TLatencyAccess        = 6,
  parameter int unsigned EnLatencyAdditional   = 1,
  parameter int unsigned TBurstMax             = 665,
  parameter int unsigned TReadWriteRecovery    = 6,
  parameter int unsigned TRxClkDelay           = 8,
  parameter int unsigned TTxClkDelay           = 8,
  parameter int unsigned TVariableLatencyCheck = 3,
  parameter int unsigned AddressSpace          = 0,
  parameter logic [31:0] ChipBase              = 32'h0,
  parameter logic [31:0] ChipSize              = 32'h40_0000,
  localparam int unsigned NumWords             = 8 + 2 * NumChips,
  localparam int unsigned IdxW                 = $clog2(NumWords)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            restart_i,
  input  logic            host_req_valid_i,
  input  logic            host_req_write_i,
  input  logic [31:0]     host_req_addr_i,
  input  logic [31:0]     host_req_wdata_i,
  input  logic [3:0]      host_req_wstrb_i,
  output logic            host_rsp_ready_o,
  output logic            host_rsp_error_o,
  output logic [31:0]     host_rsp_rdata_o,
  output logic            cfg_req_valid_o,
  output logic            cfg_req_write_o,
  output logic [31:0]     cfg_req_addr_o,
  output logic [31:0]     cfg_req_wdata_o,
  output logic [3:0]      cfg_req_wstrb_o,
  input  logic            cfg_rsp_ready_i,
  input  logic            cfg_rsp_error_i,
  input  logic [31:0]     cfg_rsp_rdata_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic [IdxW-1:0] err_idx_o
);

  localparam int unsigned CntW      = (StartDelay > 1) ? $clog2(StartDelay) : 1;
  localparam int unsigned DelayLast = (StartDelay > 0) ? StartDelay - 1 : 0;

  typedef enum logic [1:0] {ST_WAIT, ST_WR, ST_RD, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] k_q, k_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            busy_q, done_q;
  logic            fail;

  // Timing words first, then one exclusive [start, end) pair per chip.
  function automatic logic [31:0] cfg_word(input logic [IdxW-1:0] idx);
    logic [31:0] slot;
    slot = 32'(idx) - 32'd8;
    if (32'(idx) < 32'd8) begin
      case (idx[2:0])
        3'd0:    return 32'(TLatencyAccess);
        3'd1:    return 32'(EnLatencyAdditional);
        3'd2:    return 32'(TBurstMax);
        3'd3:    return 32'(TReadWriteRecovery);
        3'd4:    return 32'(TRxClkDelay);
        3'd5:    return 32'(TTxClkDelay);
        3'd6:    return 32'(TVariableLatencyCheck);
        default: return 32'(AddressSpace);
      endcase
    end
    return ChipBase + ChipSize * ((slot >> 1) + {31'b0, slot[0]});
  endfunction

  always_comb begin
    state_d          = state_q;
    k_d              = k_q;
    cnt_d            = cnt_q;
    err_d            = err_q;
    idx_d            = idx_q;
    fail             = 1'b0;
    cfg_req_valid_o  = 1'b0;
    cfg_req_write_o  = 1'b0;
    cfg_req_addr_o   = '0;
    cfg_req_wdata_o  = '0;
    cfg_req_wstrb_o  = '0;
    host_rsp_ready_o = 1'b0;
    host_rsp_error_o = 1'b0;
    host_rsp_rdata_o = '0;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q == CntW'(DelayLast)) begin
          state_d = ST_WR;
          k_d     = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_WR: begin
        cfg_req_valid_o = 1'b1;
        cfg_req_write_o = 1'b1;
        cfg_req_addr_o  = 32'(k_q) << 2;
        cfg_req_wdata_o = cfg_word(k_q);
        cfg_req_wstrb_o = 4'hF;
        if (cfg_rsp_ready_i) begin
          fail    = cfg_rsp_error_i;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        cfg_req_valid_o = 1'b1;
        cfg_req_addr_o  = 32'(k_q) << 2;
        if (cfg_rsp_ready_i) begin
          fail = cfg_rsp_error_i || (cfg_rsp_rdata_i != cfg_word(k_q));
          if (k_q == IdxW'(NumWords - 1)) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + IdxW'(1);
            state_d = ST_WR;
          end
        end
      end
      ST_DONE: begin
        cfg_req_valid_o  = host_req_valid_i;
        cfg_req_write_o  = host_req_write_i;
        cfg_req_addr_o   = host_req_addr_i;
        cfg_req_wdata_o  = host_req_wdata_i;
        cfg_req_wstrb_o  = host_req_wstrb_i;
        host_rsp_ready_o = cfg_rsp_ready_i;
        host_rsp_error_o = cfg_rsp_error_i;
        host_rsp_rdata_o = cfg_rsp_rdata_i;
        if (restart_i) begin
          state_d = ST_WAIT;
          k_d     = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          idx_d   = '0;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // Only the first failure of a run is located; later ones just keep the flag set.
    if (fail) begin
      err_d = 1'b1;
      if (!err_q) idx_d = k_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_WAIT;
      k_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != ST_DONE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign error_o   = err_q;
  assign err_idx_o = idx_q;

endmodule
